// File: rtl/hip_rst_pkg.sv
// HIP reset CPLD: shared types and defaults for the reset-request path.
// Used by hip_rst_req, its debouncer and the sequencer bench.
package hip_rst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ASSERT = 2'b01,
    HOLD   = 2'b10
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_SW   = 2'b10,
    CAUSE_BOTH = 2'b11
  } rst_cause_e;

  localparam logic [15:0] DEF_DEBOUNCE_CNT = 16'h0400;
  localparam logic [11:0] DEF_MIN_PULSE    = 12'h040;

  // Cause code for an accepted request: software bit high, button bit low.
  function automatic rst_cause_e cause_of(logic sw, logic btn);
    return rst_cause_e'({sw, btn});
  endfunction

endpackage

// File: rtl/hip_pb_debounce.sv
// Push-button synchroniser and debouncer.
// lvl_o is the debounced level as it stands after the current edge.
module hip_pb_debounce
  import hip_rst_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic clk_i,
  input  logic POR_RST_,
  input  logic pb_raw_i,
  output logic lvl_o,
  output logic press_o
);

  logic        sync1_q;
  logic        pb_s_q;
  logic        db_q;
  logic        db_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        diff;
  logic        hit;

  // Count consecutive mismatch cycles; adopt the new level on the last one.
  always_comb begin
    diff  = pb_s_q != db_q;
    hit   = diff && (cnt_q == DEBOUNCE_CNT - 16'd1);
    db_d  = db_q;
    cnt_d = 16'd0;
    if (hit) begin
      db_d = pb_s_q;
    end else if (diff) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Two-flop synchroniser plus debounce state; released button on POR.
  always_ff @(posedge clk_i or negedge POR_RST_) begin
    if (!POR_RST_) begin
      sync1_q <= 1'b1;
      pb_s_q  <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= pb_raw_i;
      pb_s_q  <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // Level and press are taken from the next state so the FSM acts
  // on the same edge that the debounced level changes.
  assign lvl_o   = db_d;
  assign press_o = db_q & ~db_d;

endmodule

// File: rtl/hip_rst_req.sv
// HIP reset-request stage: merges debounced button and software request
// into a minimum-width PUSH_RST_ and records the reset cause.
module hip_rst_req
  import hip_rst_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter logic [11:0] MIN_PULSE    = DEF_MIN_PULSE
) (
  input  logic       RST_CPLD_CLK,
  input  logic       POR_RST_,
  input  logic       PB_RAW_,
  input  logic       SW_RST_REQ,
  output logic       PUSH_RST_,
  output logic [1:0] RST_CAUSE
);

  rst_state_e  state_q;
  rst_cause_e  cause_q;
  logic [11:0] pcnt_q;
  logic        push_q;
  logic        db_lvl;
  logic        press;
  logic        pulse_done;

  hip_pb_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_db (
    .clk_i   (RST_CPLD_CLK),
    .POR_RST_(POR_RST_),
    .pb_raw_i(PB_RAW_),
    .lvl_o   (db_lvl),
    .press_o (press)
  );

  assign pulse_done = pcnt_q == MIN_PULSE - 12'd1;

  // Request FSM with registered PUSH_RST_; POR lands in ASSERT so a
  // full minimum pulse always follows power-on.
  always_ff @(posedge RST_CPLD_CLK or negedge POR_RST_) begin
    if (!POR_RST_) begin
      state_q <= ASSERT;
      pcnt_q  <= 12'd0;
      push_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press || SW_RST_REQ) begin
            state_q <= ASSERT;
            pcnt_q  <= 12'd0;
            push_q  <= 1'b0;
            cause_q <= cause_of(SW_RST_REQ, press);
          end
        end
        ASSERT: begin
          pcnt_q <= pcnt_q + 12'd1;
          if (pulse_done) begin
            pcnt_q <= 12'd0;
            if (!db_lvl) begin
              state_q <= HOLD;
            end else begin
              state_q <= IDLE;
              push_q  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (db_lvl) begin
            state_q <= IDLE;
            push_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ASSERT;
          pcnt_q  <= 12'd0;
          push_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PUSH_RST_ = push_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_hip_rst_req.sv
// Bench for hip_rst_req: per-cycle expected {PUSH_RST_, RST_CAUSE}
// queued with the stimulus and compared one entry per clock.
module tb_hip_rst_req;

  logic       clk;
  logic       por_n;
  logic       pb_n;
  logic       sw;
  logic       push_n;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       push;
    logic [1:0] cause;
    string      tag;
  } exp_t;

  exp_t sb[$];

  hip_rst_req #(
    .DEBOUNCE_CNT(16'd16),
    .MIN_PULSE   (12'd8)
  ) dut (
    .RST_CPLD_CLK(clk),
    .POR_RST_    (por_n),
    .PB_RAW_     (pb_n),
    .SW_RST_REQ  (sw),
    .PUSH_RST_   (push_n),
    .RST_CAUSE   (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [2:0] got, logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got push/cause %b want %b at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic expn(int n, logic p, logic [1:0] c, string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.push  = p;
      e.cause = c;
      e.tag   = tag;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, {push_n, cause}, {e.push, e.cause});
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) tick();
  endtask

  initial begin
    por_n = 1'b0;
    pb_n  = 1'b1;
    sw    = 1'b0;
    #1;
    chk("por_async", {push_n, cause}, 3'b000);

    // 1: POR then a full minimum pulse
    expn(5, 1'b0, 2'b00, "por_hold");
    drain();
    por_n = 1'b1;
    expn(7, 1'b0, 2'b00, "por_pulse");
    expn(1, 1'b1, 2'b00, "por_end");
    expn(4, 1'b1, 2'b00, "idle0");
    drain();

    // 2: bouncing button, then a real press
    for (int b = 0; b < 6; b++) begin
      pb_n = 1'b0;
      expn(3, 1'b1, 2'b00, "bounce_lo");
      drain();
      pb_n = 1'b1;
      expn(3, 1'b1, 2'b00, "bounce_hi");
      drain();
    end
    pb_n = 1'b0;
    expn(17, 1'b1, 2'b00, "pb_lat");
    expn(183, 1'b0, 2'b01, "pb_hold");
    drain();

    // 3: release after 200 held cycles
    pb_n = 1'b1;
    expn(17, 1'b0, 2'b01, "pb_rel");
    expn(1, 1'b1, 2'b01, "pb_rel_end");
    expn(5, 1'b1, 2'b01, "idle1");
    drain();

    // 4: software pulse, second request ignored
    sw = 1'b1;
    expn(1, 1'b0, 2'b10, "sw_fall");
    drain();
    sw = 1'b0;
    expn(2, 1'b0, 2'b10, "sw_low");
    drain();
    sw = 1'b1;
    expn(1, 1'b0, 2'b10, "sw_ign");
    drain();
    sw = 1'b0;
    expn(4, 1'b0, 2'b10, "sw_low2");
    expn(1, 1'b1, 2'b10, "sw_end");
    expn(4, 1'b1, 2'b10, "idle2");
    drain();

    // 5: software request coincident with debounced press
    pb_n = 1'b0;
    expn(17, 1'b1, 2'b10, "both_wait");
    drain();
    sw = 1'b1;
    expn(1, 1'b0, 2'b11, "both_fall");
    drain();
    sw   = 1'b0;
    pb_n = 1'b1;
    expn(17, 1'b0, 2'b11, "both_low");
    expn(1, 1'b1, 2'b11, "both_end");
    expn(6, 1'b1, 2'b11, "idle3");
    drain();

    // 6: sub-threshold glitch, then POR in HOLD
    pb_n = 1'b0;
    expn(15, 1'b1, 2'b11, "glitch");
    drain();
    pb_n = 1'b1;
    expn(25, 1'b1, 2'b11, "glitch_q");
    drain();
    pb_n = 1'b0;
    expn(17, 1'b1, 2'b11, "h_wait");
    expn(12, 1'b0, 2'b01, "h_hold");
    drain();
    por_n = 1'b0;
    pb_n  = 1'b1;
    #1;
    chk("por_mid", {push_n, cause}, 3'b000);
    expn(3, 1'b0, 2'b00, "por2_hold");
    drain();
    por_n = 1'b1;
    expn(7, 1'b0, 2'b00, "por2_pulse");
    expn(1, 1'b1, 2'b00, "por2_end");
    expn(4, 1'b1, 2'b00, "idle4");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
